// File: rtl/rether_pkg.sv
// Shared types and constants for the RMII receive framer.
package rether_pkg;

  typedef enum logic [2:0] {IDLE, PRE, DATA, DROP, EOF} state_t;

  localparam logic [1:0]  DIBIT_PRE   = 2'b01;
  localparam logic [1:0]  DIBIT_SFD   = 2'b11;
  localparam logic [31:0] CRC_POLY    = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  function automatic logic [31:0] reflect32(input logic [31:0] v);
    logic [31:0] r;
    r = '0;
    for (int unsigned i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

endpackage

// File: rtl/crc32_dibit.sv
// Reflected CRC-32, two bits per clock (rxd[0] first, as on the RMII wire).
// Only compiled when RETHER_FCS_CHECK_EN is defined.
`ifdef RETHER_FCS_CHECK_EN
module crc32_dibit
  import rether_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init,
  input  logic        en,
  input  logic [1:0]  din,
  output logic [31:0] crc
);

  localparam logic [31:0] POLY_R = reflect32(CRC_POLY);

  function automatic logic [31:0] step(input logic [31:0] c, input logic b);
    return (c >> 1) ^ ((c[0] ^ b) ? POLY_R : '0);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    crc <= CRC_INIT;
    else if (init) crc <= CRC_INIT;
    else if (en)   crc <= step(step(crc, din[0]), din[1]);
  end

endmodule
`endif

// File: rtl/rether_rx.sv
// RMII receive framer: strips preamble/SFD, emits payload dibits or bytes with
// sof/eof markers, length and status. FCS check enabled by RETHER_FCS_CHECK_EN.
module rether_rx
  import rether_pkg::*;
#(
  parameter int OUT_W     = 8,
  parameter int MIN_PRE   = 8,
  parameter int MIN_FRAME = 64,
  parameter int MAX_FRAME = 1522
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             crsdv,
  input  logic [1:0]       rxd,
  output logic             axiov,
  output logic [OUT_W-1:0] axiod,
  output logic             axio_sof,
  output logic             axio_eof,
  output logic             axio_err,
  output logic [15:0]      frame_len
);

  localparam logic [7:0]  MIN_PRE_C   = 8'(MIN_PRE);
  localparam logic [15:0] MIN_FRAME_C = 16'(MIN_FRAME);
  localparam logic [15:0] MAX_FRAME_C = 16'(MAX_FRAME);

  state_t      state, state_nx;
  logic [7:0]  pre_cnt;
  logic [1:0]  dibit_cnt;
  logic [15:0] byte_cnt;
  logic [5:0]  sh;
  logic        trunc, first;
  logic        capture, enter_data, set_trunc, crc_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    capture    = 1'b0;
    enter_data = 1'b0;
    set_trunc  = 1'b0;
    unique case (state)
      IDLE: if (crsdv) state_nx = (rxd == DIBIT_PRE) ? PRE : DROP;
      PRE: begin
        if (!crsdv) state_nx = IDLE;
        else if (rxd == DIBIT_PRE) state_nx = PRE;
        else if (rxd == DIBIT_SFD && pre_cnt >= MIN_PRE_C) begin
          state_nx   = DATA;
          enter_data = 1'b1;
        end else state_nx = DROP;
      end
      DATA: begin
        if (!crsdv) state_nx = EOF;
        else if (byte_cnt == MAX_FRAME_C) begin
          state_nx  = DROP;
          set_trunc = 1'b1;
        end else capture = 1'b1;
      end
      // A truncated frame still owes the consumer an eof; a false carrier does not.
      DROP: if (!crsdv) state_nx = trunc ? EOF : IDLE;
      EOF:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt   <= '0;
      dibit_cnt <= '0;
      byte_cnt  <= '0;
      sh        <= '0;
      trunc     <= 1'b0;
      first     <= 1'b0;
      axiov     <= 1'b0;
      axio_sof  <= 1'b0;
    end else begin
      axiov    <= 1'b0;
      axio_sof <= 1'b0;
      if (state == IDLE && crsdv && rxd == DIBIT_PRE) pre_cnt <= 8'd1;
      else if (state == PRE && crsdv && rxd == DIBIT_PRE && pre_cnt != '1)
        pre_cnt <= pre_cnt + 8'd1;
      if (enter_data) begin
        dibit_cnt <= '0;
        byte_cnt  <= '0;
        first     <= 1'b1;
      end else if (capture) begin
        dibit_cnt <= dibit_cnt + 2'd1;
        sh        <= {rxd, sh[5:2]};
        if (dibit_cnt == 2'd3) byte_cnt <= byte_cnt + 16'd1;
        if (OUT_W == 2 || dibit_cnt == 2'd3) begin
          axiov    <= 1'b1;
          axio_sof <= first;
          first    <= 1'b0;
        end
      end
      if (set_trunc)          trunc <= 1'b1;
      else if (state == EOF)  trunc <= 1'b0;
    end
  end

  if (OUT_W == 2) begin : g_dibit
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       axiod <= '0;
      else if (capture) axiod <= rxd;
    end
  end else begin : g_byte
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                              axiod <= '0;
      else if (capture && dibit_cnt == 2'd3)   axiod <= {rxd, sh};
    end
  end

`ifdef RETHER_FCS_CHECK_EN
  logic [31:0] crc;
  crc32_dibit u_crc (
    .clk   (clk),
    .rst_n (rst_n),
    .init  (enter_data),
    .en    (capture),
    .din   (rxd),
    .crc   (crc)
  );
  assign crc_bad = (crc != CRC_RESIDUE);
`else
  assign crc_bad = 1'b0;
`endif

  // Status is decoded from the held counters while in EOF; a partial byte leaves dibit_cnt non-zero.
  assign axio_eof  = (state == EOF);
  assign frame_len = (state == EOF) ? byte_cnt : '0;
  assign axio_err  = (state == EOF) &&
                     (byte_cnt < MIN_FRAME_C || dibit_cnt != 2'd0 || trunc || crc_bad);

endmodule

// File: tb/tb_rether_rx.sv
// Directed bench for rether_rx: byte build (OUT_W=8) and dibit build (OUT_W=2) share the RMII stimulus.
module tb_rether_rx;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       crsdv = 1'b0;
  logic [1:0] rxd   = 2'b00;

  always #10 clk = ~clk;

  logic        v8, sof8, eof8, err8;
  logic [7:0]  d8;
  logic [15:0] len8;
  logic        v2, sof2, eof2, err2;
  logic [1:0]  d2;
  logic [15:0] len2;

  rether_rx dut8 (
    .clk(clk), .rst_n(rst_n), .crsdv(crsdv), .rxd(rxd),
    .axiov(v8), .axiod(d8), .axio_sof(sof8), .axio_eof(eof8),
    .axio_err(err8), .frame_len(len8)
  );

  rether_rx #(.OUT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .crsdv(crsdv), .rxd(rxd),
    .axiov(v2), .axiod(d2), .axio_sof(sof2), .axio_eof(eof2),
    .axio_err(err2), .frame_len(len2)
  );

  logic [7:0] tx [0:1599];

  int unsigned n_cmp = 0, n_bad = 0;
  int unsigned cnt_v8 = 0, cnt_sof8 = 0, cnt_eof8 = 0, bad_d8 = 0, bad_proto = 0, idx8 = 0;
  int unsigned cnt_v2 = 0, cnt_sof2 = 0, cnt_eof2 = 0, bad_d2 = 0, idx2 = 0;
  logic [7:0]  sof_d8 = '0;
  logic [15:0] last_len8 = '0, last_len2 = '0;
  logic        last_err8 = 1'b0, last_err2 = 1'b0;

  int unsigned s_v8, s_eof8, s_d8, s_proto, s_v2, s_eof2, s_d2, s_sof8;

  always @(negedge clk) begin : mon
    logic [7:0] b;
    logic [1:0] e;
    if (v8) begin
      if (idx8 >= 1600 || d8 !== tx[idx8]) bad_d8++;
      if (sof8) begin
        cnt_sof8++;
        sof_d8 = d8;
        if (idx8 != 0) bad_proto++;
      end
      idx8++;
      cnt_v8++;
    end else if (sof8) bad_proto++;
    if (eof8) begin
      cnt_eof8++;
      last_len8 = len8;
      last_err8 = err8;
      if (v8 || sof8) bad_proto++;
      idx8 = 0;
    end
    if (v2) begin
      b = (idx2 / 4 < 1600) ? tx[idx2 / 4] : 8'h00;
      e = 2'(b >> (2 * (idx2 % 4)));
      if (d2 !== e) bad_d2++;
      if (sof2) begin
        cnt_sof2++;
        if (idx2 != 0) bad_proto++;
      end
      idx2++;
      cnt_v2++;
    end
    if (eof2) begin
      cnt_eof2++;
      last_len2 = len2;
      last_err2 = err2;
      if (v2 || sof2) bad_proto++;
      idx2 = 0;
    end
    if (!rst_n) begin
      idx8 = 0;
      idx2 = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] fcs(input int unsigned n);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int unsigned i = 0; i < n; i++) begin
      c = c ^ {24'h0, tx[i]};
      for (int unsigned k = 0; k < 8; k++)
        c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic build_good();
    logic [31:0] c;
    for (int unsigned i = 0; i < 1600; i++) tx[i] = 8'h00;
    for (int unsigned i = 0; i < 6; i++) tx[i] = 8'hFF;
    tx[6] = 8'h02; tx[7] = 8'h11; tx[8] = 8'h22; tx[9] = 8'h33; tx[10] = 8'h44; tx[11] = 8'h55;
    tx[12] = 8'h00; tx[13] = 8'h02; tx[14] = 8'h34; tx[15] = 8'h12;
    c = fcs(60);
    tx[60] = c[7:0]; tx[61] = c[15:8]; tx[62] = c[23:16]; tx[63] = c[31:24];
  endtask

  task automatic send_dibit(input logic [1:0] d);
    crsdv = 1'b1;
    rxd   = d;
    @(negedge clk);
  endtask

  task automatic send_frame(input int unsigned npre, input int unsigned nbytes,
                            input int unsigned xdib, input int unsigned gap);
    for (int unsigned i = 0; i < npre; i++) send_dibit(2'b01);
    send_dibit(2'b11);
    for (int unsigned i = 0; i < nbytes; i++)
      for (int unsigned k = 0; k < 4; k++) send_dibit(2'(tx[i] >> (2 * k)));
    for (int unsigned k = 0; k < xdib; k++) send_dibit(2'(tx[nbytes] >> (2 * k)));
    crsdv = 1'b0;
    rxd   = 2'b00;
    repeat (gap) @(negedge clk);
  endtask

  task automatic snap();
    s_v8 = cnt_v8; s_eof8 = cnt_eof8; s_d8 = bad_d8; s_proto = bad_proto; s_sof8 = cnt_sof8;
    s_v2 = cnt_v2; s_eof2 = cnt_eof2; s_d2 = bad_d2;
  endtask

  task automatic check_rx(input string t, input int unsigned ev, input int unsigned eeof,
                          input logic [15:0] elen, input logic eerr);
    check({t, "_nvalid"}, cnt_v8 - s_v8, ev);
    check({t, "_neof"}, cnt_eof8 - s_eof8, eeof);
    check({t, "_data"}, bad_d8 - s_d8, 0);
    check({t, "_proto"}, bad_proto - s_proto, 0);
    if (eeof != 0) begin
      check({t, "_len"}, last_len8, elen);
      check({t, "_err"}, last_err8, eerr);
      check({t, "_nsof"}, cnt_sof8 - s_sof8, eeof);
    end
  endtask

  initial begin
    logic flip_err;
    build_good();
    repeat (3) @(negedge clk);
    check("rst_axiov", v8, 0);
    check("rst_sof", sof8, 0);
    check("rst_eof", eof8, 0);
    check("rst_err", err8, 0);
    check("rst_axiod", d8, 0);
    check("rst_len", len8, 0);
    check("rst_axiov2", v2, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Good frame
    snap();
    send_frame(28, 64, 0, 6);
    check_rx("good", 64, 1, 16'd64, 1'b0);
    check("good_sof_data", sof_d8, 8'hFF);
    check("good2_nvalid", cnt_v2 - s_v2, 256);
    check("good2_data", bad_d2 - s_d2, 0);
    check("good2_neof", cnt_eof2 - s_eof2, 1);
    check("good2_len", last_len2, 64);
    check("good2_err", last_err2, 0);

    // One data bit flipped, FCS left as-is
`ifdef RETHER_FCS_CHECK_EN
    flip_err = 1'b1;
`else
    flip_err = 1'b0;
`endif
    tx[14] = tx[14] ^ 8'h01;
    snap();
    send_frame(28, 64, 0, 6);
    check_rx("flip", 64, 1, 16'd64, flip_err);

    // False carrier, then a normal frame
    build_good();
    snap();
    for (int unsigned i = 0; i < 10; i++) send_dibit(2'b01);
    for (int unsigned i = 0; i < 3; i++) send_dibit(2'b10);
    crsdv = 1'b0;
    rxd   = 2'b00;
    repeat (6) @(negedge clk);
    check_rx("fcar", 0, 0, 16'd0, 1'b0);
    check("fcar2_nvalid", cnt_v2 - s_v2, 0);
    snap();
    send_frame(28, 64, 0, 6);
    check_rx("after_fcar", 64, 1, 16'd64, 1'b0);

    // Short frame ending on a partial byte
    snap();
    send_frame(28, 61, 2, 6);
    check_rx("short", 61, 1, 16'd61, 1'b1);
    check("short2_len", last_len2, 61);
    check("short2_err", last_err2, 1);

    // Back-to-back: next preamble starts as soon as IDLE is re-entered
    snap();
    send_frame(28, 64, 0, 2);
    send_frame(28, 64, 0, 6);
    check_rx("b2b", 128, 2, 16'd64, 1'b0);

    // Oversize frame truncated at MAX_FRAME
    for (int unsigned i = 16; i < 1600; i++) tx[i] = 8'(i);
    snap();
    send_frame(28, 1600, 0, 6);
    check_rx("over", 1522, 1, 16'd1522, 1'b1);
    check("over2_nvalid", cnt_v2 - s_v2, 1522 * 4);
    check("over2_data", bad_d2 - s_d2, 0);
    check("over2_len", last_len2, 1522);
    check("over2_err", last_err2, 1);

    // Reset asserted mid-DATA, right after a byte has been presented
    build_good();
    snap();
    for (int unsigned i = 0; i < 28; i++) send_dibit(2'b01);
    send_dibit(2'b11);
    for (int unsigned i = 0; i < 10; i++)
      for (int unsigned k = 0; k < 4; k++) send_dibit(2'(tx[i] >> (2 * k)));
    check("midrst_pre_valid", v8, 1);
    check("midrst_pre_data", d8, 8'h33);
    rst_n = 1'b0;
    crsdv = 1'b0;
    rxd   = 2'b00;
    #1;
    check("midrst_axiov", v8, 0);
    check("midrst_axiod", d8, 0);
    check("midrst_sof", sof8, 0);
    check("midrst_eof", eof8, 0);
    check("midrst_len", len8, 0);
    check("midrst_axiov2", v2, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("midrst_noeof", cnt_eof8 - s_eof8, 0);
    check("midrst_noeof2", cnt_eof2 - s_eof2, 0);
    snap();
    send_frame(28, 64, 0, 6);
    check_rx("after_rst", 64, 1, 16'd64, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
